// File: rtl/elevator_pkg.sv
// Shared types and constants for the elevator car sequencer.
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DOOR = 2'd2
  } state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int unsigned DEFAULT_NUM_FLOORS = 8;

endpackage

// File: rtl/floor_mask_search.sv
// Reports whether any request is pending strictly above or strictly below a floor.
module floor_mask_search
  import elevator_pkg::*;
#(
  parameter int unsigned NUM_FLOORS = DEFAULT_NUM_FLOORS,
  parameter int unsigned FLOOR_W    = 3
) (
  input  logic [NUM_FLOORS-1:0] pending,
  input  logic [FLOOR_W-1:0]    cur,
  output logic                  above,
  output logic                  below
);

  always_comb begin
    above = 1'b0;
    below = 1'b0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      if (i > 32'(cur)) above = above | pending[i];
      if (i < 32'(cur)) below = below | pending[i];
    end
  end

endmodule

// File: rtl/elevator_scheduler.sv
// Single-car SCAN scheduler: latches floor requests, steps the car one floor per
// TRAVEL_CYCLES and holds the door for DOOR_CYCLES at each served floor.
module elevator_scheduler
  import elevator_pkg::*;
#(
  parameter int unsigned NUM_FLOORS    = DEFAULT_NUM_FLOORS,
  parameter int unsigned FLOOR_W       = 3,
  parameter int unsigned TRAVEL_CYCLES = 4,
  parameter int unsigned DOOR_CYCLES   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic [FLOOR_W-1:0]    req_floor,
  output logic [FLOOR_W-1:0]    current_floor,
  output logic                  direction,
  output logic                  moving,
  output logic                  door_open,
  output logic                  arrive,
  output logic [NUM_FLOORS-1:0] pending
);

  localparam int unsigned TIMER_W = $clog2(TRAVEL_CYCLES + DOOR_CYCLES);
  localparam logic [TIMER_W-1:0] TRAVEL_LOAD = TIMER_W'(TRAVEL_CYCLES - 1);
  localparam logic [TIMER_W-1:0] DOOR_LOAD   = TIMER_W'(DOOR_CYCLES - 1);

  state_t                  state;
  logic [TIMER_W-1:0]      timer;
  logic [FLOOR_W-1:0]      nxt;
  logic                    nxt_hit;
  logic                    above, below, nxt_above, nxt_below;
  logic                    door_hold;
  logic [NUM_FLOORS-1:0]   set_mask, clr_mask;

  // Floor the car reaches when the current one-floor move completes.
  assign nxt     = (direction == DIR_UP) ? current_floor + FLOOR_W'(1)
                                         : current_floor - FLOOR_W'(1);
  assign nxt_hit = (32'(nxt) < NUM_FLOORS) && pending[nxt];

  floor_mask_search #(.NUM_FLOORS(NUM_FLOORS), .FLOOR_W(FLOOR_W)) u_search_cur (
    .pending (pending),
    .cur     (current_floor),
    .above   (above),
    .below   (below)
  );

  floor_mask_search #(.NUM_FLOORS(NUM_FLOORS), .FLOOR_W(FLOOR_W)) u_search_nxt (
    .pending (pending),
    .cur     (nxt),
    .above   (nxt_above),
    .below   (nxt_below)
  );

  // A request for the open-door floor extends the door instead of latching.
  always_comb begin
    set_mask  = '0;
    clr_mask  = '0;
    door_hold = 1'b0;
    if (req_valid && (32'(req_floor) < NUM_FLOORS)) begin
      if (state == DOOR && req_floor == current_floor) door_hold = 1'b1;
      else set_mask[req_floor] = 1'b1;
    end
    if (state == IDLE && pending[current_floor]) clr_mask[current_floor] = 1'b1;
    if (state == MOVE && timer == '0 && nxt_hit) clr_mask[nxt] = 1'b1;
  end

  assign moving    = (state == MOVE);
  assign door_open = (state == DOOR);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      current_floor <= '0;
      direction     <= DIR_UP;
      pending       <= '0;
      arrive        <= 1'b0;
      timer         <= '0;
    end else begin
      pending <= (pending | set_mask) & ~clr_mask;
      arrive  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pending[current_floor]) begin
            state <= DOOR;
            timer <= DOOR_LOAD;
          end else if (above && (direction || !below)) begin
            direction <= DIR_UP;
            state     <= MOVE;
            timer     <= TRAVEL_LOAD;
          end else if (below) begin
            direction <= DIR_DOWN;
            state     <= MOVE;
            timer     <= TRAVEL_LOAD;
          end
        end
        MOVE: begin
          if (timer != '0) begin
            timer <= timer - TIMER_W'(1);
          end else begin
            current_floor <= nxt;
            arrive        <= 1'b1;
            if (nxt_hit) begin
              state <= DOOR;
              timer <= DOOR_LOAD;
            end else if (direction ? nxt_above : nxt_below) begin
              timer <= TRAVEL_LOAD;
            end else if (direction ? nxt_below : nxt_above) begin
              direction <= ~direction;
              timer     <= TRAVEL_LOAD;
            end else begin
              state <= IDLE;
            end
          end
        end
        DOOR: begin
          if (door_hold) begin
            timer <= DOOR_LOAD;
          end else if (timer != '0) begin
            timer <= timer - TIMER_W'(1);
          end else if (direction ? above : below) begin
            state <= MOVE;
            timer <= TRAVEL_LOAD;
          end else if (direction ? below : above) begin
            direction <= ~direction;
            state     <= MOVE;
            timer     <= TRAVEL_LOAD;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
